// File: rtl/plru_array_if.sv
// Request/response bundle for the tree-PLRU array: access and lookup requests in,
// flush status and the registered victim out.
interface plru_array_if #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 8
);
  logic                        access_valid;
  logic [$clog2(NUM_SETS)-1:0] access_set;
  logic [$clog2(NUM_WAYS)-1:0] access_way;
  logic                        lookup_valid;
  logic [$clog2(NUM_SETS)-1:0] lookup_set;
  logic [NUM_WAYS-1:0]         valid_mask;
  logic                        flush;
  logic                        busy;
  logic                        victim_valid;
  logic [$clog2(NUM_WAYS)-1:0] victim_way;

  modport master (
    output access_valid, access_set, access_way,
    output lookup_valid, lookup_set, valid_mask, flush,
    input  busy, victim_valid, victim_way
  );

  modport slave (
    input  access_valid, access_set, access_way,
    input  lookup_valid, lookup_set, valid_mask, flush,
    output busy, victim_valid, victim_way
  );
endinterface

// File: rtl/plru_array.sv
// Tree pseudo-LRU state for NUM_SETS sets of NUM_WAYS ways, with invalid-way
// preference, same-cycle access bypass and a one-set-per-cycle flush walk.
module plru_array #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 8
) (
  input  logic       clk,
  input  logic       rst,
  plru_array_if.slave bus
);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TREE_W = NUM_WAYS - 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [SET_W-1:0]   cnt_reg, cnt_next;
  logic [TREE_W-1:0]  tree_reg [NUM_SETS];
  logic               victim_valid_reg;
  logic [WAY_W-1:0]   victim_way_reg;

  logic               in_idle, access_ok, lookup_ok, clear_en;
  logic [TREE_W-1:0]  access_tree, lookup_tree;
  logic [WAY_W-1:0]   tree_way, free_way, victim_sel;
  logic               free_found;

  // Point every node on the path to the touched way towards the other subtree.
  function automatic logic [TREE_W-1:0] touch(input logic [TREE_W-1:0] bits,
                                               input logic [WAY_W-1:0]  way);
    logic [TREE_W-1:0] r;
    int                n;
    r = bits;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[n[WAY_W-1:0]] = ~way[WAY_W-1-l];
      n = 2 * n + 1 + int'(way[WAY_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] walk(input logic [TREE_W-1:0] bits);
    logic [WAY_W-1:0] v;
    int               n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = bits[n[WAY_W-1:0]];
      n = 2 * n + 1 + int'(bits[n[WAY_W-1:0]]);
    end
    return v;
  endfunction

  assign in_idle   = (state_reg == IDLE);
  assign clear_en  = (state_reg == FLUSH);
  assign access_ok = in_idle && !bus.flush && bus.access_valid;
  assign lookup_ok = in_idle && !bus.flush && bus.lookup_valid;
  assign bus.busy  = clear_en;

  assign access_tree = touch(tree_reg[bus.access_set], bus.access_way);
  assign lookup_tree = (access_ok && (bus.access_set == bus.lookup_set))
                       ? access_tree : tree_reg[bus.lookup_set];
  assign tree_way    = walk(lookup_tree);

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!bus.valid_mask[i]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(i);
      end
    end
  end

  assign victim_sel = free_found ? free_way : tree_way;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.flush) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        if (cnt_reg == SET_W'(NUM_SETS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One register bank per set so the flush walk and accesses each touch a single set.
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tree_reg[gi] <= '0;
      end else if (clear_en && (cnt_reg == SET_W'(gi))) begin
        tree_reg[gi] <= '0;
      end else if (access_ok && (bus.access_set == SET_W'(gi))) begin
        tree_reg[gi] <= access_tree;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      victim_valid_reg <= 1'b0;
      victim_way_reg   <= '0;
    end else begin
      victim_valid_reg <= lookup_ok;
      if (lookup_ok) begin
        victim_way_reg <= victim_sel;
      end
    end
  end

  assign bus.victim_valid = victim_valid_reg;
  assign bus.victim_way   = victim_way_reg;
endmodule

// File: tb/tb_plru_array.sv
// Scoreboard bench for plru_array (16 sets x 8 ways): every driven cycle pushes its
// expected victim response, and a negedge monitor pops and compares it.
module tb_plru_array;
  logic clk;
  logic rst;

  plru_array_if #(.NUM_SETS(16), .NUM_WAYS(8)) bus ();

  plru_array #(.NUM_SETS(16), .NUM_WAYS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    int w;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("victim_valid", int'(bus.victim_valid), int'(e.v));
        if (e.v) check_eq("victim_way", int'(bus.victim_way), e.w);
      end else if (bus.victim_valid) begin
        check_eq("spurious_victim", int'(bus.victim_valid), 0);
      end
    end
  end

  task automatic do_cycle(input bit a_v, input int a_s, input int a_w,
                          input bit l_v, input int l_s, input logic [7:0] mask,
                          input bit fl, input bit exp_v, input int exp_w);
    exp_t e;
    #1;
    bus.access_valid = a_v;
    bus.access_set   = 4'(a_s);
    bus.access_way   = 3'(a_w);
    bus.lookup_valid = l_v;
    bus.lookup_set   = 4'(l_s);
    bus.valid_mask   = mask;
    bus.flush        = fl;
    @(posedge clk);
    e.v = exp_v;
    e.w = exp_w;
    sb_q.push_back(e);
    $display("txn acc=%0d set=%0d way=%0d | look=%0d set=%0d mask=%h | flush=%0d | exp v=%0d way=%0d",
             a_v, a_s, a_w, l_v, l_s, mask, fl, exp_v, exp_w);
  endtask

  task automatic idle_cycle();
    do_cycle(0, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
  endtask

  task automatic access(input int s, input int w);
    do_cycle(1, s, w, 0, 0, 8'hFF, 0, 0, 0);
  endtask

  task automatic lookup(input int s, input logic [7:0] mask, input int w);
    do_cycle(0, 0, 0, 1, s, mask, 0, 1, w);
  endtask

  task automatic clear_inputs();
    bus.access_valid = 1'b0;
    bus.access_set   = '0;
    bus.access_way   = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_set   = '0;
    bus.valid_mask   = 8'hFF;
    bus.flush        = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_victim_valid", int'(bus.victim_valid), 0);
    check_eq("rst_victim_way", int'(bus.victim_way), 0);
    #21 rst = 1'b1;

    // Fresh tree, then a single touch of way 0 sends the victim to the right half.
    lookup(3, 8'hFF, 0);
    access(3, 0);
    lookup(3, 8'hFF, 4);
    lookup(4, 8'hFF, 0);

    access(5, 0);
    access(5, 4);
    access(5, 2);
    access(5, 6);
    lookup(5, 8'hFF, 1);

    lookup(7, 8'b1111_0111, 3);
    lookup(7, 8'b0111_1111, 7);
    lookup(3, 8'b1111_0111, 3);
    lookup(3, 8'b0000_0000, 0);
    idle_cycle();

    // Same-cycle access and lookup: bypass on the same set, isolation on another.
    do_cycle(1, 2, 0, 1, 2, 8'hFF, 0, 1, 4);
    lookup(2, 8'hFF, 4);
    do_cycle(1, 6, 0, 1, 8, 8'hFF, 0, 1, 0);
    lookup(6, 8'hFF, 4);

    // Flush beats same-cycle requests; everything is ignored while busy.
    do_cycle(1, 0, 0, 1, 3, 8'hFF, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("busy_during_flush", int'(bus.busy), 1);
      do_cycle(i > 1, 0, 0, 1, 3, 8'hFF, 1, 0, 0);
    end
    #1;
    check_eq("busy_after_flush", int'(bus.busy), 0);
    for (int s = 0; s < 16; s++) lookup(s, 8'hFF, 0);

    // Reset in the middle of a flush walk clears everything immediately.
    access(9, 0);
    lookup(9, 8'hFF, 4);
    do_cycle(0, 0, 0, 0, 0, 8'hFF, 1, 0, 0);
    for (int i = 0; i < 5; i++) idle_cycle();
    #1;
    check_eq("busy_mid_flush", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_busy", int'(bus.busy), 0);
    check_eq("async_rst_victim_valid", int'(bus.victim_valid), 0);
    check_eq("async_rst_victim_way", int'(bus.victim_way), 0);
    sb_q.delete();
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    lookup(9, 8'hFF, 0);
    access(1, 7);
    lookup(1, 8'hFF, 0);
    access(1, 0);
    lookup(1, 8'hFF, 4);

    for (int i = 0; i < 3; i++) idle_cycle();
    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
